// File: rtl/qs_fifo_prog.sv
// ============================================================================
// qs_fifo_prog : synchronous FIFO, any depth >= 2, occupancy count, programmable
//                almost-full/empty, registered read. Option: QS_FIFO_ERR_FLAGS_EN
// Revision     : 1.0
// ============================================================================
`default_nettype none

module qs_fifo_prog #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              pop_valid_o,
    output logic [$clog2(DEPTH+1 > 2 ? DEPTH+1 : 2)-1:0] count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int c_PTR_W = clog2_f(DEPTH);
    localparam int c_CNT_W = clog2_f(DEPTH + 1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [DATA_W-1:0]  r_pop_data;
    logic               r_pop_valid;
    logic               w_full;
    logic               w_empty;
    logic               w_push_acc;
    logic               w_pop_acc;

    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push_acc = push_i & ~w_full;
    assign w_pop_acc  = pop_i & ~w_empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && w_push_acc) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr   <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
                r_pop_data <= r_mem[r_rd_ptr];
            end
            r_pop_valid <= w_pop_acc;
            if (w_push_acc && !w_pop_acc) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop_acc && !w_push_acc) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

`ifdef QS_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky until reset: a single misuse stays visible to slow monitors.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push_i && w_full)  r_overflow  <= 1'b1;
            if (pop_i  && w_empty) r_underflow <= 1'b1;
        end
    end

    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

    assign pop_data_o     = r_pop_data;
    assign pop_valid_o    = r_pop_valid;
    assign count_o        = r_count;
    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (r_count >= c_CNT_W'(AF_THRESH));
    assign almost_empty_o = (r_count <= c_CNT_W'(AE_THRESH));

endmodule

`default_nettype wire

// File: tb/tb_qs_fifo_prog.sv
// ============================================================================
// tb_qs_fifo_prog : directed + random stimulus against a queue-based model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_qs_fifo_prog;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 5;
    localparam int AF_THRESH = 3;
    localparam int AE_THRESH = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              push_i = 1'b0;
    logic [DATA_W-1:0] push_data_i = '0;
    logic              pop_i = 1'b0;
    logic [DATA_W-1:0] pop_data_o;
    logic              pop_valid_o;
    logic [2:0]        count_o;
    logic              full_o;
    logic              empty_o;
    logic              almost_full_o;
    logic              almost_empty_o;
    logic              overflow_o;
    logic              underflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ovf;
    logic              m_udf;

    qs_fifo_prog #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_THRESH(AF_THRESH),
        .AE_THRESH(AE_THRESH)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .push_i        (push_i),
        .push_data_i   (push_data_i),
        .pop_i         (pop_i),
        .pop_data_o    (pop_data_o),
        .pop_valid_o   (pop_valid_o),
        .count_o       (count_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .almost_full_o (almost_full_o),
        .almost_empty_o(almost_empty_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: model advances on the pre-edge occupancy, then every output is compared.
    task automatic step(input logic rst, input logic psh, input logic [DATA_W-1:0] d, input logic pp);
        int  sz;
        bit  pa, pq;
        reset       = rst;
        push_i      = psh;
        push_data_i = d;
        pop_i       = pp;
        sz = m_q.size();
        if (rst) begin
            m_q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            pa = psh && (sz != DEPTH);
            pq = pp && (sz != 0);
            if (psh && sz == DEPTH) m_ovf = 1'b1;
            if (pp && sz == 0)      m_udf = 1'b1;
            m_valid = pq;
            if (pq) m_data = m_q.pop_front();
            if (pa) m_q.push_back(d);
        end
        @(posedge clk);
        #1;
        sz = m_q.size();
        check_eq("count",        count_o,        sz);
        check_eq("empty",        empty_o,        sz == 0);
        check_eq("full",         full_o,         sz == DEPTH);
        check_eq("almost_full",  almost_full_o,  sz >= AF_THRESH);
        check_eq("almost_empty", almost_empty_o, sz <= AE_THRESH);
        check_eq("pop_valid",    pop_valid_o,    m_valid);
        check_eq("pop_data",     pop_data_o,     m_data);
`ifdef QS_FIFO_ERR_FLAGS_EN
        check_eq("overflow",     overflow_o,     m_ovf);
        check_eq("underflow",    underflow_o,    m_udf);
`else
        check_eq("overflow",     overflow_o,     1'b0);
        check_eq("underflow",    underflow_o,    1'b0);
`endif
    endtask

    initial begin
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;

        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);

        // Fill, overfill, drain, underflow
        for (int i = 0; i < 5; i++) step(0, 1, 8'h11 + 8'(i), 0);
        step(0, 1, 8'h99, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Non-power-of-two wrap
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h30 + 8'(i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 8'hA0 + 8'(i), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);

        // Simultaneous push+pop at count 2, then at full
        step(0, 1, 8'h41, 0);
        step(0, 1, 8'h42, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h5A + 8'(i), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h60 + 8'(i), 0);
        step(0, 1, 8'hEE, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);

        // Push+pop at count 0 (pop ignored) and at count 1
        step(0, 1, 8'h21, 1);
        step(0, 1, 8'h22, 1);
        step(0, 0, 8'h00, 1);

        // Reset mid-stream with concurrent traffic
        for (int i = 0; i < 3; i++) step(0, 1, 8'hC0 + 8'(i), 0);
        step(1, 1, 8'hCC, 1);
        step(0, 1, 8'h77, 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            logic r, p, q;
            r = ($urandom_range(0, 63) == 0);
            p = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 35));
            q = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 70));
            step(r, p, 8'($urandom), q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
